// File: rtl/snake_pkg.sv
// ============================================================================
// Module      : snake_pkg
// Description : Shared direction codes, scheduler states and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snake_pkg;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;
  localparam logic [2:0] DIR_PAUSE = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    ISSUE = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  function automatic logic [2:0] opposite_dir(input logic [2:0] dir);
    case (dir)
      DIR_UP:    opposite_dir = DIR_DOWN;
      DIR_DOWN:  opposite_dir = DIR_UP;
      DIR_LEFT:  opposite_dir = DIR_RIGHT;
      DIR_RIGHT: opposite_dir = DIR_LEFT;
      default:   opposite_dir = DIR_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/snake_dir_fifo.sv
// ============================================================================
// Module      : snake_dir_fifo
// Description : Small synchronous FIFO of 3-bit direction codes; also exposes
//               the most recently written entry for duplicate filtering.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_dir_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [2:0]               din,
  output logic [2:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [2:0]               last
);

  localparam int AW = $clog2(DEPTH);

  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [2:0]    r_last;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign last      = r_last;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_last   <= din;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/snake_move_scheduler.sv
// ============================================================================
// Module      : snake_move_scheduler
// Description : Queues direction presses, generates the movement tick and
//               issues one move per tick to GameLogic; owns pause/game-over.
//               Optional macro REVERSE_FILTER_EN discards reversing heads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_move_scheduler
  import snake_pkg::*;
#(
  parameter int TICK_CYCLES = 4000000,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_code,
  input  logic       btn_valid,
  input  logic       move_ready,
  input  logic       game_over,
  output logic       move_valid,
  output logic [2:0] move_dir,
  output logic       paused,
  output logic [2:0] fifo_count,
  output logic       dropped
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic [2:0]                r_heading, w_heading_nxt;
  logic                      r_pause_pend, w_pause_pend_nxt;
  logic                      r_dropped;
  logic                      w_is_dir, w_pause_req, w_accept, w_tick;
  logic                      w_push, w_pop, w_push_drop, w_rev_drop;
  logic                      w_full, w_empty;
  logic [2:0]                w_head, w_last, w_ref_dir;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  snake_dir_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (btn_code),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .last  (w_last)
  );

  // Duplicate presses compare against the newest queued entry, or the
  // heading once the queue has drained.
  assign w_is_dir    = btn_valid && (btn_code >= DIR_UP) && (btn_code <= DIR_RIGHT);
  assign w_pause_req = btn_valid && (btn_code == DIR_PAUSE);
  assign w_ref_dir   = w_empty ? r_heading : w_last;
  assign w_accept    = w_is_dir && (r_state != OVER) && (btn_code != w_ref_dir);
  assign w_push      = w_accept && !w_full;
  assign w_push_drop = w_accept && w_full;
  assign w_tick      = (r_cnt == TICK_LAST);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_heading_nxt    = r_heading;
    w_pause_pend_nxt = r_pause_pend;
    w_pop            = 1'b0;
    w_rev_drop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_heading_nxt = w_head;
          w_cnt_nxt     = '0;
          w_state_nxt   = RUN;
        end
      end
      RUN: begin
        if (game_over) begin
          w_state_nxt = OVER;
        end else if (w_pause_req) begin
          w_state_nxt = PAUSE;
        end else if (w_tick) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ISSUE;
          if (!w_empty) begin
            w_pop = 1'b1;
`ifdef REVERSE_FILTER_EN
            if (w_head == opposite_dir(r_heading)) begin
              w_rev_drop = 1'b1;
            end else begin
              w_heading_nxt = w_head;
            end
`else
            w_heading_nxt = w_head;
`endif
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ISSUE: begin
        if (game_over) begin
          w_state_nxt      = OVER;
          w_pause_pend_nxt = 1'b0;
        end else if (move_ready) begin
          w_state_nxt      = (r_pause_pend || w_pause_req) ? PAUSE : RUN;
          w_pause_pend_nxt = 1'b0;
        end else if (w_pause_req) begin
          w_pause_pend_nxt = 1'b1;
        end
      end
      PAUSE: begin
        if (game_over) begin
          w_state_nxt = OVER;
        end else if (w_pause_req) begin
          w_state_nxt = RUN;
        end
      end
      OVER: begin
        w_state_nxt = OVER;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_heading    <= DIR_NONE;
      r_pause_pend <= 1'b0;
      r_dropped    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_heading    <= w_heading_nxt;
      r_pause_pend <= w_pause_pend_nxt;
      r_dropped    <= w_push_drop || w_rev_drop;
    end
  end

  assign move_valid = (r_state == ISSUE);
  assign paused     = (r_state == PAUSE);
  assign move_dir   = r_heading;
  assign fifo_count = 3'(w_count);
  assign dropped    = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_snake_move_scheduler.sv
// ============================================================================
// Module      : tb_snake_move_scheduler
// Description : Directed self-checking bench for snake_move_scheduler
//               (TICK_CYCLES=10, FIFO_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snake_move_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn_code = 3'd0;
  logic       btn_valid = 1'b0;
  logic       move_ready = 1'b0;
  logic       game_over = 1'b0;
  logic       move_valid;
  logic [2:0] move_dir;
  logic       paused;
  logic [2:0] fifo_count;
  logic       dropped;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snake_move_scheduler #(
    .TICK_CYCLES (10),
    .FIFO_DEPTH  (4),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_code   (btn_code),
    .btn_valid  (btn_valid),
    .move_ready (move_ready),
    .game_over  (game_over),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .paused     (paused),
    .fifo_count (fifo_count),
    .dropped    (dropped)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] code);
    btn_code  = code;
    btn_valid = 1'b1;
    step();
    btn_valid = 1'b0;
    btn_code  = 3'd0;
  endtask

  // Edges until move_valid is seen, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!move_valid && n < 60) begin
      step();
      n++;
    end
  endtask

  int n;
  int bad;
  logic [2:0] exp_seq [4];

  initial begin
`ifdef REVERSE_FILTER_EN
    exp_seq = '{3'd1, 3'd1, 3'd3, 3'd1};
`else
    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd1};
`endif
    repeat (3) step();
    rst = 1'b0;
    step();
    check_val("rst_valid", 32'(move_valid), 0);
    check_val("rst_dir", 32'(move_dir), 0);
    check_val("rst_paused", 32'(paused), 0);
    check_val("rst_count", 32'(fifo_count), 0);
    check_val("rst_dropped", 32'(dropped), 0);

    // First move: valid rises 11 edges after the push edge.
    move_ready = 1'b1;
    press(3'd4);
    check_val("idle_count", 32'(fifo_count), 1);
    step();
    check_val("run_dir", 32'(move_dir), 4);
    check_val("run_count", 32'(fifo_count), 0);
    check_val("run_valid", 32'(move_valid), 0);
    wait_valid(n);
    check_val("first_latency", n, 10);
    check_val("first_dir", 32'(move_dir), 4);
    step();
    check_val("valid_one_cycle", 32'(move_valid), 0);

    // Stalled handshake.
    move_ready = 1'b0;
    wait_valid(n);
    check_val("tick_period", n, 10);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (!move_valid || move_dir != 3'd4) bad++;
    end
    check_val("stall_hold", bad, 0);
    check_val("stall_count", 32'(fifo_count), 0);

    // Fill the queue while stalled; fifth press overflows.
    press(3'd1);
    press(3'd2);
    press(3'd3);
    press(3'd1);
    check_val("fill_no_drop", 32'(dropped), 0);
    press(3'd2);
    check_val("full_drop", 32'(dropped), 1);
    check_val("full_count", 32'(fifo_count), 4);
    step();
    check_val("drop_pulse_end", 32'(dropped), 0);
    check_val("stall_dir", 32'(move_dir), 4);

    move_ready = 1'b1;
    step();
    check_val("release_valid", 32'(move_valid), 0);
    for (int k = 0; k < 4; k++) begin
      wait_valid(n);
      check_val("seq_valid", 32'(move_valid), 1);
      check_val("seq_dir", 32'(move_dir), 32'(exp_seq[k]));
      if (k == 1) begin
`ifdef REVERSE_FILTER_EN
        check_val("rev_drop", 32'(dropped), 1);
`else
        check_val("rev_drop", 32'(dropped), 0);
`endif
      end
      step();
    end
    check_val("drained_count", 32'(fifo_count), 0);

    // Pause with the counter at 5; resume finishes the remaining 5 counts.
    repeat (5) step();
    press(3'd5);
    check_val("paused_on", 32'(paused), 1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (move_valid || !paused) bad++;
    end
    check_val("pause_hold", bad, 0);
    move_ready = 1'b0;
    press(3'd5);
    check_val("paused_off", 32'(paused), 0);
    wait_valid(n);
    check_val("resume_latency", n, 5);

    // Game over during a stalled issue.
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    check_val("over_valid", 32'(move_valid), 0);
    press(3'd3);
    check_val("over_no_push", 32'(fifo_count), 0);
    press(3'd5);
    move_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (move_valid || paused || dropped || move_dir != 3'd1) bad++;
    end
    check_val("over_frozen", bad, 0);

    #3 rst = 1'b1;
    #1;
    check_val("over_rst_dir", 32'(move_dir), 0);
    check_val("over_rst_valid", 32'(move_valid), 0);
    step();
    rst = 1'b0;
    press(3'd3);
    step();
    check_val("post_rst_dir", 32'(move_dir), 3);
    press(3'd3);
    check_val("dup_ignored", 32'(fifo_count), 0);
    check_val("dup_no_drop", 32'(dropped), 0);

    // Asynchronous reset mid-cycle during ISSUE.
    move_ready = 1'b0;
    wait_valid(n);
    check_val("pre_async_valid", 32'(move_valid), 1);
    #2 rst = 1'b1;
    #1;
    check_val("async_valid", 32'(move_valid), 0);
    check_val("async_dir", 32'(move_dir), 0);
    step();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/snake_move_scheduler.md
Name: snake_move_scheduler

Overview:
- Sits between the button path (`manejo_entradas`) and `GameLogic`.
- Buffers debounced direction presses in a small FIFO and generates the movement tick itself.
- Once per tick it issues exactly one movement command (heading) to `GameLogic` over a valid/ready handshake.
- Owns pause and game-over sequencing, replacing the ad-hoc tick/state logic in the top level.

Parameters:
- TICK_CYCLES, 4000000, clk cycles between movement ticks (>=2).
- FIFO_DEPTH, 4, direction queue entries (power of two, >=2).
- CNT_W, 23, tick counter width; must satisfy 2^CNT_W > TICK_CYCLES.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- btn_code  in  3  encoding: 0 none, 1 up, 2 down, 3 left, 4 right, 5 pause; 6 and 7 are ignored.
- btn_valid  in  1  one-cycle strobe qualifying btn_code.
- move_ready  in  1  GameLogic accepts the current move.
- game_over  in  1  level from GameLogic; collision detected.
- move_valid  out  1  movement command pending.
- move_dir  out  3  heading, codes 1-4; 0 before the first move.
- paused  out  1  high while in PAUSE.
- fifo_count  out  3  current queue occupancy.
- dropped  out  1  one-cycle pulse when a press is discarded.

Behaviour:
- Reset (async, any state): all outputs 0, FIFO empty, tick counter 0, heading 0, state IDLE.

Push rules, evaluated on btn_valid:
- Code 5 never enters the FIFO; it requests a pause toggle.
- Codes 0, 6 and 7 are ignored, with no dropped pulse.
- A direction code equal to the last queued entry (or to the heading if the FIFO is empty) is ignored, with no pulse.
- A direction code with the FIFO full is discarded and pulses dropped.
- Fullness is judged on pre-cycle occupancy, so a push and pop in the same cycle with a full FIFO still drops the push.
- A simultaneous push and pop on a non-full FIFO leaves the count unchanged.

States:
- IDLE
  - On a non-empty FIFO: pop the head, heading <= head, counter <= 0, go to RUN.
  - Pause requests are ignored.
- RUN
  - Counter increments each cycle; at TICK_CYCLES-1 it wraps to 0 and generates a tick.
  - On tick: pop the head if non-empty; apply the reversal rule (see Optional Feature), else heading <= head; go to ISSUE.
  - The heading update is visible on move_dir in the same cycle move_valid rises, one cycle after the tick.
  - A pause request in RUN goes to PAUSE; the counter holds its value.
- ISSUE
  - move_valid = 1; move_dir stable.
  - On move_ready: move_valid falls the next cycle and the state returns to RUN.
  - Counter frozen.
  - A pause request is latched and applied on the transition back to RUN (enters PAUSE instead).
- PAUSE
  - paused = 1; counter frozen; FIFO still accepts pushes.
  - A pause request returns to RUN, resuming the counter from its held value.
- OVER
  - move_valid = 0; counter and FIFO frozen; pushes ignored.
  - Exit only by rst.
- game_over high in RUN, ISSUE or PAUSE goes to OVER on the next edge, overriding every other transition.
- This is the sole case where move_valid may fall without move_ready.

Handshake:
- move_dir must not change while move_valid = 1.
- At most one move is issued per tick.
- No move is issued while in IDLE, PAUSE or OVER.

Optional Feature:
- Macro: REVERSE_FILTER_EN.
- Defined: at pop time, a head equal to the opposite of the current heading (1<->2, 3<->4) is discarded.
  - The heading is kept and dropped pulses.
  - The pop still consumes one tick's slot.
- Undefined: no reversal check; the head always becomes the heading, and collision handling is left to GameLogic.

Decomposition:
- Package snake_pkg:
  - direction code constants (DIR_NONE..DIR_PAUSE);
  - state enum (IDLE, RUN, ISSUE, PAUSE, OVER);
  - constant function opposite_dir().
- Sub-module snake_dir_fifo: synchronous FIFO of depth FIFO_DEPTH.
  - Ports: push, pop, din[2:0], dout[2:0], full, empty, count, last (most recently written entry).
  - Same clk/rst.

Test Plan (TICK_CYCLES=10):
- After reset, push 4 (right) -> next cycle RUN with move_dir=4; first move_valid rises 11 cycles later; ready held high -> valid lasts 1 cycle.
- Hold move_ready=0 for 30 cycles -> move_valid stays 1, move_dir stays 4, no second move issued, fifo_count unaffected by the stall.
- With heading 4, push 1,2,3,1,2 in 5 consecutive cycles while ISSUE is stalled -> the 5th press pulses dropped, fifo_count=4; the next four ticks pop the entries in order.
  - Expected sequence with REVERSE_FILTER_EN: 1, 2 discarded (reverse of 1; heading stays 1), 3, 1.
  - Expected sequence without: 1, 2, 3, 1.
- Pause at counter=5 in RUN -> paused=1, no moves for 50 cycles; pause again -> first move 5 cycles later.
- game_over during ISSUE with ready=0 -> move_valid=0 on the next edge, state OVER, all further presses and ticks ignored; rst mid-OVER -> all outputs 0, IDLE.
- Assert rst asynchronously between clock edges while in ISSUE -> move_valid falls immediately, not at the next edge.
